// File: rtl/mmio_io_ctrl.sv
// Memory-mapped board I/O: HEX/LEDR/LEDG output registers, synchronised KEY/SW inputs and sticky KEY-press flags.
// Define IO_DEBOUNCE_EN to add a per-bit stable-count debounce filter on every KEY and SW bit.
module mmio_io_ctrl #(
    parameter int                 DBITS       = 32,
    parameter int                 NKEYS       = 4,
    parameter int                 NSW         = 10,
    parameter int                 NLEDR       = 10,
    parameter int                 NLEDG       = 8,
    parameter int                 HEXBITS     = 16,
    parameter logic [HEXBITS-1:0] HEXRESET    = 16'hDEAD,
    parameter int                 DEBOUNCE    = 500000,
    parameter logic [DBITS-1:0]   ADDRHEX     = 32'hF0000000,
    parameter logic [DBITS-1:0]   ADDRLEDR    = 32'hF0000004,
    parameter logic [DBITS-1:0]   ADDRLEDG    = 32'hF0000008,
    parameter logic [DBITS-1:0]   ADDRKEY     = 32'hF0000010,
    parameter logic [DBITS-1:0]   ADDRSW      = 32'hF0000014,
    parameter logic [DBITS-1:0]   ADDRKEYEDGE = 32'hF0000018
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [DBITS-1:0]   addr,
    input  logic [DBITS-1:0]   wdata,
    input  logic               we,
    output logic               sel,
    output logic [DBITS-1:0]   rdata,
    input  logic [NKEYS-1:0]   KEY,
    input  logic [NSW-1:0]     SW,
    output logic [HEXBITS-1:0] hex_out,
    output logic [NLEDR-1:0]   ledr,
    output logic [NLEDG-1:0]   ledg
);
    localparam int NIN = NKEYS + NSW;

    // KEY occupies the low bits, inverted so 1 means pressed
    logic [NIN-1:0]   raw, sync1, sync2, stable, stable_nx;
    logic [NKEYS-1:0] edge_flag, key_rise, clr_mask;
    logic             wr_hex, wr_ledr, wr_ledg, wr_edge;

    assign raw = {SW, ~KEY};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            stable <= stable_nx;
        end
    end

`ifdef IO_DEBOUNCE_EN
    localparam int             CW   = $clog2(DEBOUNCE);
    localparam logic [CW-1:0]  CMAX = CW'(DEBOUNCE - 1);

    logic [CW-1:0] cnt [NIN];

    for (genvar i = 0; i < NIN; i++) begin : g_deb
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
                cnt[i] <= '0;
            else if (sync2[i] == stable[i] || cnt[i] == CMAX)
                cnt[i] <= '0;
            else
                cnt[i] <= cnt[i] + 1'b1;
        end
        // Adopt the synchronised value only after DEBOUNCE consecutive differing cycles
        assign stable_nx[i] = (sync2[i] != stable[i] && cnt[i] == CMAX) ? sync2[i] : stable[i];
    end : g_deb

    logic unused_in;
    assign unused_in = ^wdata;
`else
    assign stable_nx = sync2;

    logic unused_in;
    assign unused_in = ^{wdata, DEBOUNCE};
`endif

    assign wr_hex  = we && (addr == ADDRHEX);
    assign wr_ledr = we && (addr == ADDRLEDR);
    assign wr_ledg = we && (addr == ADDRLEDG);
    assign wr_edge = we && (addr == ADDRKEYEDGE);

    // Flag rises on the same edge the stable press appears; a simultaneous W1C loses
    assign key_rise = stable_nx[NKEYS-1:0] & ~stable[NKEYS-1:0];
    assign clr_mask = wr_edge ? wdata[NKEYS-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex_out   <= HEXRESET;
            ledr      <= '0;
            ledg      <= '0;
            edge_flag <= '0;
        end else begin
            if (wr_hex)  hex_out <= wdata[HEXBITS-1:0];
            if (wr_ledr) ledr    <= wdata[NLEDR-1:0];
            if (wr_ledg) ledg    <= wdata[NLEDG-1:0];
            edge_flag <= (edge_flag & ~clr_mask) | key_rise;
        end
    end

    always_comb begin
        sel   = 1'b1;
        rdata = '0;
        case (addr)
            ADDRHEX:     rdata[HEXBITS-1:0] = hex_out;
            ADDRLEDR:    rdata[NLEDR-1:0]   = ledr;
            ADDRLEDG:    rdata[NLEDG-1:0]   = ledg;
            ADDRKEY:     rdata[NKEYS-1:0]   = stable[NKEYS-1:0];
            ADDRSW:      rdata[NSW-1:0]     = stable[NIN-1:NKEYS];
            ADDRKEYEDGE: rdata[NKEYS-1:0]   = edge_flag;
            default: begin
                sel   = 1'b0;
                rdata = DBITS'(32'hDEADBEEF);
            end
        endcase
    end
endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed bench for mmio_io_ctrl (DEBOUNCE=4); follows IO_DEBOUNCE_EN for input latency.
module tb_mmio_io_ctrl;
`ifdef IO_DEBOUNCE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 3;
`endif
    localparam logic [31:0] A_HEX  = 32'hF0000000, A_LEDR = 32'hF0000004, A_LEDG = 32'hF0000008;
    localparam logic [31:0] A_KEY  = 32'hF0000010, A_SW   = 32'hF0000014, A_EDGE = 32'hF0000018;
    localparam logic [31:0] A_BAD  = 32'hF0000020;

    logic        clk = 1'b0, reset_n = 1'b0, we = 1'b0, sel;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic [3:0]  KEY = 4'hF;
    logic [9:0]  SW = '0, ledr;
    logic [15:0] hex_out;
    logic [7:0]  ledg;
    int          checks = 0, errors = 0;

    mmio_io_ctrl #(.DEBOUNCE(4)) dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .wdata(wdata), .we(we),
        .sel(sel), .rdata(rdata), .KEY(KEY), .SW(SW),
        .hex_out(hex_out), .ledr(ledr), .ledg(ledg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        tick(1);
        we = 1'b0;
    endtask

    task automatic rdchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    initial begin
        tick(3);
        @(negedge clk) reset_n = 1'b1;
        tick(1);
        chk("rst_hex", 32'(hex_out), 32'h0000DEAD);
        chk("rst_ledr", 32'(ledr), 32'h0);
        chk("rst_ledg", 32'(ledg), 32'h0);
        rdchk("rst_edge", A_EDGE, 32'h0);
        rdchk("rst_key", A_KEY, 32'h0);

        wr(A_HEX, 32'h1234ABCD);
        wr(A_LEDR, 32'hFFFFFFFF);
        wr(A_LEDG, 32'h000001A5);
        chk("hex_out", 32'(hex_out), 32'h0000ABCD);
        chk("ledr", 32'(ledr), 32'h000003FF);
        chk("ledg", 32'(ledg), 32'h000000A5);
        rdchk("rd_hex", A_HEX, 32'h0000ABCD);
        chk("sel_hex", 32'(sel), 32'h1);
        rdchk("rd_ledr", A_LEDR, 32'h000003FF);
        rdchk("rd_ledg", A_LEDG, 32'h000000A5);
        wr(A_SW, 32'hFFFFFFFF);
        rdchk("sw_ro", A_SW, 32'h0);

        // Press KEY[0]: invisible one edge early, visible at LAT
        KEY = 4'b1110;
        tick(LAT - 1);
        rdchk("key_early", A_KEY, 32'h0);
        tick(1);
        rdchk("key_press", A_KEY, 32'h1);
        rdchk("edge_set", A_EDGE, 32'h1);
        KEY = 4'b1111;
        tick(LAT + 2);
        rdchk("key_rel", A_KEY, 32'h0);
        rdchk("edge_sticky", A_EDGE, 32'h1);

        SW = 10'h2A5;
        tick(LAT);
        rdchk("sw_read", A_SW, 32'h000002A5);

        // New press rising on the same edge as a W1C of that bit
        KEY = 4'b1110;
        tick(LAT - 1);
        addr = A_EDGE; wdata = 32'h1; we = 1'b1;
        tick(1);
        we = 1'b0;
        rdchk("set_wins", A_EDGE, 32'h1);
        wr(A_EDGE, 32'h1);
        rdchk("w1c", A_EDGE, 32'h0);
        KEY = 4'b1111;
        tick(LAT + 2);
        rdchk("rel_noset", A_EDGE, 32'h0);

        KEY = 4'b0011;
        tick(LAT);
        rdchk("key_multi", A_KEY, 32'h0000000C);
        rdchk("edge_multi", A_EDGE, 32'h0000000C);
        wr(A_EDGE, 32'h4);
        rdchk("w1c_part", A_EDGE, 32'h8);
        KEY = 4'b1111;
        tick(LAT + 2);
        wr(A_EDGE, 32'hF);

`ifdef IO_DEBOUNCE_EN
        KEY = 4'b1101;
        tick(3);
        KEY = 4'b1111;
        tick(10);
        rdchk("glitch_key", A_KEY, 32'h0);
        rdchk("glitch_edge", A_EDGE, 32'h0);
        KEY = 4'b1101;
        tick(5);
        rdchk("deb_early", A_KEY, 32'h0);
        tick(1);
        rdchk("deb_press", A_KEY, 32'h2);
        rdchk("deb_edge", A_EDGE, 32'h2);
        tick(4);
        KEY = 4'b1111;
        tick(8);
`endif

        rdchk("unmap_rd", A_BAD, 32'hDEADBEEF);
        chk("unmap_sel", 32'(sel), 32'h0);
        wr(A_BAD, 32'h00000000);
        chk("unmap_hex", 32'(hex_out), 32'h0000ABCD);
        chk("unmap_ledr", 32'(ledr), 32'h000003FF);
        chk("unmap_ledg", 32'(ledg), 32'h000000A5);

        // Asynchronous reset assertion mid-cycle
        KEY = 4'b1110;
        tick(LAT);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_hex", 32'(hex_out), 32'h0000DEAD);
        chk("arst_ledr", 32'(ledr), 32'h0);
        rdchk("arst_edge", A_EDGE, 32'h0);
        rdchk("arst_key", A_KEY, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
